// File: rtl/mdp_pkg.sv
// Shared types for svi_req_queue: controller states and the queued command record.
// The command record is sized by CMD_AW/CMD_DW; the queue's AW/DW must not exceed them.
package mdp_pkg;

  localparam int CMD_AW = 16;
  localparam int CMD_DW = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/svi_req_queue_if.sv
// Upstream command, SVI request/response and upstream completion signals of svi_req_queue.
// The master modport is the queue's own view; slave is the surrounding environment.
interface svi_req_queue_if #(
  parameter int AW = 16,
  parameter int DW = 32
);

  logic          in_valid;
  logic          in_ready;
  logic          in_write;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata;

  logic          m_valid;
  logic          m_ready;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    input  in_valid, in_write, in_addr, in_wdata, m_ready, m_rvalid, m_rdata,
    output in_ready, m_valid, m_write, m_addr, m_wdata, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output in_valid, in_write, in_addr, in_wdata, m_ready, m_rvalid, m_rdata,
    input  in_ready, m_valid, m_write, m_addr, m_wdata, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/svi_req_fifo.sv
// Circular command FIFO with one wrap bit on each pointer; pushes while full are dropped.
module svi_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 49
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;
  logic         w_push_ok;
  logic         w_pop_ok;

  // Equal index with differing wrap bits means the writer is a full lap ahead.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/svi_req_queue.sv
// Request queue issuing buffered commands on SVI one at a time and returning read data upstream.
// Define SVI_REQ_QUEUE_TIMEOUT_EN to complete unanswered reads after TMO cycles with rsp_err=1.
module svi_req_queue
  import mdp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = CMD_AW,
  parameter int DW    = CMD_DW,
  parameter int TMO   = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  svi_req_queue_if.master bus
);

  state_t        r_state;
  state_t        w_next;
  cmd_t          w_push_cmd;
  cmd_t          w_head;
  cmd_t          r_cmd;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_rsp_ok;
  logic          w_rsp_tmo;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;

`ifdef SVI_REQ_QUEUE_TIMEOUT_EN
  logic [7:0]    r_cnt;
  logic          r_rsp_err;
`endif

  assign w_push_cmd = {bus.in_write, CMD_AW'(bus.in_addr), CMD_DW'(bus.in_wdata)};

  svi_req_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_rsp_ok  = 1'b0;
    w_rsp_tmo = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ready) w_next = r_cmd.write ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        // A response arriving on the expiry cycle takes priority over the timeout.
        if (bus.m_rvalid) begin
          w_rsp_ok = 1'b1;
          w_next   = IDLE;
        end
`ifdef SVI_REQ_QUEUE_TIMEOUT_EN
        else if (r_cnt == 8'd1) begin
          w_rsp_tmo = 1'b1;
          w_next    = IDLE;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_pop) r_cmd <= w_head;
      r_rsp_valid <= w_rsp_ok || w_rsp_tmo;
      if (w_rsp_ok)       r_rsp_rdata <= bus.m_rdata;
      else if (w_rsp_tmo) r_rsp_rdata <= '0;
    end
  end

`ifdef SVI_REQ_QUEUE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_rsp_tmo;
      if (r_state == ISSUE && bus.m_ready && !r_cmd.write) r_cnt <= 8'(TMO);
      else if (r_state == WAIT_RSP && !bus.m_rvalid)      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.in_ready  = !w_full;
  assign bus.m_valid   = (r_state == ISSUE);
  assign bus.m_write   = r_cmd.write;
  assign bus.m_addr    = AW'(r_cmd.addr);
  assign bus.m_wdata   = DW'(r_cmd.wdata);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_svi_req_queue.sv
// Bench for svi_req_queue: directed scenarios with literal expectations plus randomized traffic vs a queue model.
// Define SVI_REQ_QUEUE_TIMEOUT_EN for both bench and RTL to cover the read-response timeout.
module tb_svi_req_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int TMO   = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  svi_req_queue_if #(.AW(AW), .DW(DW)) bus ();

  svi_req_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .TMO   (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          write;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
  } cmdRec;

  // Model: pending commands, the one on the bus, and whether a read answer is owed.
  cmdRec       pending[$];
  cmdRec       onBus = '{default: 0};
  bit          offering = 0;
  bit          awaiting = 0;
  int          waitLeft = 0;
  bit          expRspValid = 0;
  bit          expRspErr = 0;
  bit [DW-1:0] expRdata = '0;

  int nCompared = 0;
  int nMismatch = 0;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    cmdRec c;
    bit    accept;
    if (!rst_n) begin
      pending.delete();
      onBus       = '{default: 0};
      offering    = 0;
      awaiting    = 0;
      waitLeft    = 0;
      expRspValid = 0;
      expRspErr   = 0;
      expRdata    = '0;
      return;
    end
    accept      = bus.in_valid && (pending.size() < DEPTH);
    expRspValid = 0;
    expRspErr   = 0;
    if (offering) begin
      if (bus.m_ready) begin
        offering = 0;
        if (!onBus.write) begin
          awaiting = 1;
          waitLeft = TMO;
        end
      end
    end else if (awaiting) begin
      if (bus.m_rvalid) begin
        expRspValid = 1;
        expRdata    = bus.m_rdata;
        awaiting    = 0;
      end
`ifdef SVI_REQ_QUEUE_TIMEOUT_EN
      else begin
        waitLeft--;
        if (waitLeft == 0) begin
          expRspValid = 1;
          expRspErr   = 1;
          expRdata    = '0;
          awaiting    = 0;
        end
      end
`endif
    end else if (pending.size() > 0) begin
      onBus    = pending.pop_front();
      offering = 1;
    end
    if (accept) begin
      c.write = bus.in_write;
      c.addr  = bus.in_addr;
      c.wdata = bus.in_wdata;
      pending.push_back(c);
    end
  endtask

  always @(posedge clk) modelStep();

  task automatic checkOutput();
    checkVal("in_ready",  bus.in_ready,  rst_n ? (pending.size() < DEPTH) : 1'b1);
    checkVal("m_valid",   bus.m_valid,   rst_n ? offering : 1'b0);
    checkVal("m_write",   bus.m_write,   rst_n ? onBus.write : 1'b0);
    checkVal("m_addr",    bus.m_addr,    rst_n ? onBus.addr : '0);
    checkVal("m_wdata",   bus.m_wdata,   rst_n ? onBus.wdata : '0);
    checkVal("rsp_valid", bus.rsp_valid, rst_n ? expRspValid : 1'b0);
    checkVal("rsp_err",   bus.rsp_err,   rst_n ? expRspErr : 1'b0);
    checkVal("rsp_rdata", bus.rsp_rdata, rst_n ? expRdata : '0);
  endtask

  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input bit inValid, input bit inWrite, input logic [AW-1:0] inAddr,
                               input logic [DW-1:0] inWdata, input bit mReady, input bit mRvalid,
                               input logic [DW-1:0] mRdata);
    bus.in_valid = inValid;
    bus.in_write = inWrite;
    bus.in_addr  = inAddr;
    bus.in_wdata = inWdata;
    bus.m_ready  = mReady;
    bus.m_rvalid = mRvalid;
    bus.m_rdata  = mRdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_in_ready"},  bus.in_ready,  1);
    checkVal({tag, "_m_valid"},   bus.m_valid,   0);
    checkVal({tag, "_m_write"},   bus.m_write,   0);
    checkVal({tag, "_m_addr"},    bus.m_addr,    0);
    checkVal({tag, "_m_wdata"},   bus.m_wdata,   0);
    checkVal({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    checkVal({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    checkVal({tag, "_rsp_err"},   bus.rsp_err,   0);
  endtask

  logic [AW-1:0] issued[$];

  initial begin
    applyStimulus(0, 0, '0, '0, 0, 0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkResetValues("reset");
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Single write with the slave always ready: one m_valid cycle two cycles after the push.
    applyStimulus(1, 1, 16'h0010, 32'hDEADBEEF, 1, 0, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    @(negedge clk);
    checkVal("d1_mvalid_c1", bus.m_valid, 0);
    nextCycle();
    @(negedge clk);
    checkVal("d1_mvalid_c2", bus.m_valid, 1);
    checkVal("d1_mwrite_c2", bus.m_write, 1);
    checkVal("d1_maddr_c2",  bus.m_addr,  16'h0010);
    checkVal("d1_mwdata_c2", bus.m_wdata, 32'hDEADBEEF);
    nextCycle();
    @(negedge clk);
    checkVal("d1_mvalid_c3", bus.m_valid, 0);
    checkVal("d1_rspv_c3",   bus.rsp_valid, 0);
    nextCycle();

    // Stalled read, stray m_rvalid during ISSUE, then a real response.
    applyStimulus(1, 0, 16'h0020, '0, 0, 0, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0);
    @(negedge clk);
    checkVal("d2_mvalid_c1", bus.m_valid, 0);
    nextCycle();
    @(negedge clk);
    checkVal("d2_mvalid_c2", bus.m_valid, 1);
    checkVal("d2_maddr_c2",  bus.m_addr,  16'h0020);
    checkVal("d2_mwrite_c2", bus.m_write, 0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 0, 1, 32'hBAD0BAD0);
    @(negedge clk);
    checkVal("d2_maddr_c3", bus.m_addr, 16'h0020);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0);
    @(negedge clk);
    checkVal("d2_mvalid_c4", bus.m_valid, 1);
    checkVal("d2_rspv_c4",   bus.rsp_valid, 0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    @(negedge clk);
    checkVal("d2_mvalid_c5", bus.m_valid, 1);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0);
    @(negedge clk);
    checkVal("d2_mvalid_c6", bus.m_valid, 0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 0, 1, 32'h12345678);
    @(negedge clk);
    checkVal("d2_rspv_c7", bus.rsp_valid, 0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0);
    @(negedge clk);
    checkVal("d2_rspv_c8",  bus.rsp_valid, 1);
    checkVal("d2_rdata_c8", bus.rsp_rdata, 32'h12345678);
    checkVal("d2_err_c8",   bus.rsp_err,   0);
    nextCycle();
    @(negedge clk);
    checkVal("d2_rspv_c9", bus.rsp_valid, 0);

    // Park a read in WAIT_RSP, then push five writes: the fifth finds the queue full.
    nextCycle();
    applyStimulus(1, 0, 16'h0030, '0, 1, 0, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(1, 1, 16'h0100 + AW'(i), $urandom, 0, 0, '0);
      @(negedge clk);
      checkVal($sformatf("d3_in_ready_push%0d", i), bus.in_ready, (i < 4) ? 1 : 0);
    end
    nextCycle();
    applyStimulus(0, 0, '0, '0, 0, 1, 32'h00C0FFEE);
    @(negedge clk);
    checkVal("d3_in_ready_full", bus.in_ready, 0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) issued.push_back(bus.m_addr);
      nextCycle();
    end
    checkVal("d3_issue_count", issued.size(), 4);
    for (int k = 0; k < issued.size() && k < 4; k++)
      checkVal($sformatf("d3_issue_order%0d", k), issued[k], 16'h0100 + AW'(k));

    // Read that is never answered, followed by a write.
    applyStimulus(1, 0, 16'h0040, '0, 1, 0, '0);
    nextCycle();
    applyStimulus(1, 1, 16'h0044, 32'hCAFE0044, 1, 0, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    for (int c = 3; c <= 19; c++) begin
      nextCycle();
      @(negedge clk);
      if (c == 17) checkVal("d4_rspv_c17", bus.rsp_valid, 0);
`ifdef SVI_REQ_QUEUE_TIMEOUT_EN
      if (c == 18) begin
        checkVal("d4_rspv_c18",  bus.rsp_valid, 1);
        checkVal("d4_err_c18",   bus.rsp_err,   1);
        checkVal("d4_rdata_c18", bus.rsp_rdata, 0);
      end
      if (c == 19) begin
        checkVal("d4_mvalid_c19", bus.m_valid, 1);
        checkVal("d4_maddr_c19",  bus.m_addr,  16'h0044);
      end
`else
      if (c == 18) checkVal("d4_rspv_c18", bus.rsp_valid, 0);
      if (c == 19) checkVal("d4_mvalid_c19", bus.m_valid, 0);
`endif
    end
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 1, 32'h0BADF00D);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    repeat (6) nextCycle();

    // Reset while a read is outstanding and two writes are queued.
    applyStimulus(1, 0, 16'h0050, '0, 1, 0, '0);
    nextCycle();
    applyStimulus(1, 1, 16'h0054, 32'h54545454, 1, 0, '0);
    nextCycle();
    applyStimulus(1, 1, 16'h0058, 32'h58585858, 1, 0, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    nextCycle();
    rst_n = 1'b0;
    applyStimulus(0, 0, '0, '0, 1, 1, 32'hFFFFFFFF);
    @(negedge clk);
    checkResetValues("d5_inreset");
    nextCycle();
    @(negedge clk);
    checkVal("d5_rspv_inreset2", bus.rsp_valid, 0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkVal($sformatf("d5_in_ready_%0d", k), bus.in_ready, 1);
      checkVal($sformatf("d5_mvalid_%0d", k), bus.m_valid, 0);
      checkVal($sformatf("d5_rspv_%0d", k), bus.rsp_valid, 0);
      nextCycle();
    end

    // Randomized traffic with one reset in the middle; the model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                    $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 20, $urandom);
      if (n == 1500) rst_n = 1'b0;
      if (n == 1503) rst_n = 1'b1;
      nextCycle();
    end
    applyStimulus(0, 0, '0, '0, 1, 0, '0);
    nextCycle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
